// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI snoop controller: line states, snooped bus
// messages, the controller FSM state and the post-snoop target state helper.
package mesi_pkg;

    typedef enum logic [1:0] {
        ST_M = 2'b00,
        ST_E = 2'b01,
        ST_S = 2'b10,
        ST_I = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        MSG_RH = 2'b00,
        MSG_RM = 2'b01,
        MSG_WH = 2'b10,
        MSG_WM = 2'b11
    } msg_t;

    typedef enum logic {
        FSM_IDLE    = 1'b0,
        FSM_WB_WAIT = 1'b1
    } fsm_t;

    // A read-miss by another cache demotes us to S; a write-miss invalidates.
    function automatic mesi_t snoop_target(msg_t m);
        return (m == MSG_RM) ? ST_S : ST_I;
    endfunction

endpackage

// File: rtl/mesi_snoop_decode.sv
// Combinational action decode for one snooped message against one line state:
// ignore it, update the line directly, or start a write-back first.
module mesi_snoop_decode
    import mesi_pkg::*;
(
    input  mesi_t line_state,
    input  msg_t  msg,
    output logic  ignore,
    output logic  update,
    output logic  wb,
    output mesi_t next_state
);

    always_comb begin
        ignore     = 1'b0;
        update     = 1'b0;
        wb         = 1'b0;
        next_state = line_state;
        if (line_state == ST_I || msg == MSG_RH || msg == MSG_WH) begin
            ignore = 1'b1;
        end else if (line_state == ST_M) begin
            // Dirty data must reach memory before the line can change.
            wb = 1'b1;
        end else begin
            update     = 1'b1;
            next_state = snoop_target(msg);
        end
    end

endmodule

// File: rtl/mesi_snoop_ctrl.sv
// MESI snoop controller: per-line state array, snoop sequencing with a
// write-back wait for modified lines, and a local state-write port.
module mesi_snoop_ctrl
    import mesi_pkg::*;
#(
    parameter int LINES = 4,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             snp_valid,
    output logic             snp_ready,
    input  logic [1:0]       snp_msg,
    input  logic [IDX_W-1:0] snp_idx,
    input  logic             loc_valid,
    output logic             loc_ready,
    input  logic [IDX_W-1:0] loc_idx,
    input  logic [1:0]       loc_state,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_state,
    output logic             wb_req,
    output logic [IDX_W-1:0] wb_idx,
    input  logic             wb_ack,
    output logic             abt_mem_acs,
    output logic             snp_done,
    output logic             faz_nada
);

    // Handshakes: a snoop transfers on a rising edge where snp_valid & snp_ready,
    // a local write where loc_valid & loc_ready; ready never depends on valid
    // of the same channel, and all effects appear the following cycle.

    mesi_t lines [LINES];
    fsm_t  fsm_state, fsm_next;
    msg_t  wb_msg;

    logic  dec_ignore, dec_update, dec_wb;
    mesi_t dec_next;
    logic  snp_acc, loc_acc, ack_acc;

    mesi_snoop_decode u_decode (
        .line_state (lines[snp_idx]),
        .msg        (msg_t'(snp_msg)),
        .ignore     (dec_ignore),
        .update     (dec_update),
        .wb         (dec_wb),
        .next_state (dec_next)
    );

    assign snp_ready   = (fsm_state == FSM_IDLE);
    assign snp_acc     = snp_valid && snp_ready;
    assign ack_acc     = (fsm_state == FSM_WB_WAIT) && wb_ack;
    // Local writes may not race the line currently being snooped or written back.
    assign loc_ready   = !(((fsm_state == FSM_WB_WAIT) && (loc_idx == wb_idx)) ||
                           (snp_acc && (loc_idx == snp_idx)));
    assign loc_acc     = loc_valid && loc_ready;
    assign rd_state    = lines[rd_idx];
    assign wb_req      = (fsm_state == FSM_WB_WAIT);
    assign abt_mem_acs = (fsm_state == FSM_WB_WAIT);

    always_comb begin
        fsm_next = fsm_state;
        case (fsm_state)
            FSM_IDLE:    if (snp_acc && dec_wb) fsm_next = FSM_WB_WAIT;
            FSM_WB_WAIT: if (wb_ack)            fsm_next = FSM_IDLE;
            default:                            fsm_next = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_state <= FSM_IDLE;
            wb_idx    <= '0;
            wb_msg    <= MSG_RH;
            snp_done  <= 1'b0;
            faz_nada  <= 1'b0;
            for (int i = 0; i < LINES; i++) lines[i] <= ST_I;
        end else begin
            fsm_state <= fsm_next;
            snp_done  <= (snp_acc && dec_update) || ack_acc;
            faz_nada  <= snp_acc && dec_ignore;
            if (snp_acc && dec_wb) begin
                wb_idx <= snp_idx;
                wb_msg <= msg_t'(snp_msg);
            end
            // Snoop, ack and local targets are disjoint by construction of loc_ready.
            if (ack_acc)               lines[wb_idx]  <= snoop_target(wb_msg);
            if (snp_acc && dec_update) lines[snp_idx] <= dec_next;
            if (loc_acc)               lines[loc_idx] <= mesi_t'(loc_state);
        end
    end

endmodule

// File: doc/mesi_snoop_ctrl.md
MESI_SNOOP_CTRL -- requirements
Module: mesi_snoop_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 4, meaning number of tracked cache lines (power of two, >=2).
REQ-002 SHALL have parameter IDX_W, default $clog2(LINES), meaning line index width.
REQ-003 SHALL have port clock  in  1  meaning single clock, rising edge.
REQ-004 SHALL have port reset  in  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port snp_valid  in  1  meaning snooped bus message present.
REQ-006 SHALL have port snp_ready  out  1  meaning controller accepts a snoop this cycle.
REQ-007 SHALL have port snp_msg  in  2  meaning bus message: 00 rh, 01 rm, 10 wh, 11 wm.
REQ-008 SHALL have port snp_idx  in  IDX_W  meaning line targeted by the snoop.
REQ-009 SHALL have port loc_valid  in  1  meaning local (own-CPU) state write request.
REQ-010 SHALL have port loc_ready  out  1  meaning local write accepted this cycle.
REQ-011 SHALL have port loc_idx  in  IDX_W  meaning line for the local write.
REQ-012 SHALL have port loc_state  in  2  meaning new state: 00 M, 01 E, 10 S, 11 I.
REQ-013 SHALL have port rd_idx  in  IDX_W  meaning state read address.
REQ-014 SHALL have port rd_state  out  2  meaning combinational state of line rd_idx.
REQ-015 SHALL have port wb_req  out  1  meaning write-back request to memory.
REQ-016 SHALL have port wb_idx  out  IDX_W  meaning line being written back.
REQ-017 SHALL have port wb_ack  in  1  meaning memory has completed the write-back.
REQ-018 SHALL have port abt_mem_acs  out  1  meaning abort the requester's memory access.
REQ-019 SHALL have port snp_done  out  1  meaning one-cycle pulse: snoop caused a state change.
REQ-020 SHALL have port faz_nada  out  1  meaning one-cycle pulse: snoop ignored.

Function
REQ-021 SHALL hold a LINES x 2-bit state array; rd_state combinational from it.
REQ-022 SHALL implement FSM IDLE/WB_WAIT; snp_ready = 1 only in IDLE.
REQ-023 Snoop accepted on snp_valid & snp_ready; all effects registered, visible next cycle.
REQ-024 rh or wh (any state), or any msg to an I line: no state change, faz_nada pulses next cycle.
REQ-025 E or S line, rm: line -> S next cycle, snp_done pulses, wb_req and abt_mem_acs stay 0.
REQ-026 E or S line, wm: line -> I next cycle, snp_done pulses, wb_req and abt_mem_acs stay 0.
REQ-027 M line, rm or wm: next cycle enter WB_WAIT, wb_req=1, abt_mem_acs=1, wb_idx=snp_idx; msg latched.
REQ-028 In WB_WAIT: wb_req, abt_mem_acs, wb_idx held stable until the cycle wb_ack=1 is sampled.
REQ-029 On wb_ack in WB_WAIT: line -> S (latched rm) or I (latched wm), wb_req/abt_mem_acs deassert, snp_done pulses, FSM -> IDLE, all next cycle.
REQ-030 wb_ack outside WB_WAIT SHALL be ignored.
REQ-031 loc_ready = 0 when in WB_WAIT and loc_idx == wb_idx, or when a snoop is accepted the same cycle with loc_idx == snp_idx; else 1.
REQ-032 Accepted local write updates the line next cycle; write to a different index in the same cycle as a snoop SHALL both take effect.
REQ-033 Back-to-back snoops SHALL be accepted every cycle while in IDLE (throughput 1/cycle for non-M hits).

Reset
REQ-034 Reset SHALL asynchronously set all lines to I, FSM to IDLE, and wb_req, abt_mem_acs, snp_done, faz_nada, wb_idx to 0.
REQ-035 Reset during WB_WAIT SHALL abandon the write-back; the line is I after reset.

Structure
REQ-036 mesi_pkg SHALL hold state encodings (M,E,S,I), message encodings (RH,RM,WH,WM) and the FSM state typedef.
REQ-037 Next-state/action decode per (state,msg) SHALL be sub-module mesi_snoop_decode (combinational); sequencing and array stay in mesi_snoop_ctrl.

Verification
REQ-038 Reset, then rd_idx 0..LINES-1 -> rd_state = 11 for every line; all outputs 0.
REQ-039 loc write line 2 = E (01); snoop rm idx 2 -> next cycle rd_state(2)=10, snp_done=1, wb_req=0.
REQ-040 line 1 = M; snoop wm idx 1; wb_ack held 0 for 5 cycles -> wb_req=abt_mem_acs=1, wb_idx=1, snp_ready=0 throughout; ack -> line 1 = 11, snp_done pulse.
REQ-041 line 3 = S; snoop rh idx 3, then wh idx 3 back-to-back -> two faz_nada pulses, line stays 10.
REQ-042 In WB_WAIT on idx 1: loc write idx 1 -> loc_ready=0, no change; loc write idx 0 = M -> accepted, rd_state(0)=00.
REQ-043 Assert reset mid WB_WAIT -> wb_req/abt_mem_acs drop immediately, all lines 11, snp_ready=1 after release.
